// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan decoder.
// Segment patterns are active-low, bit0 = a through bit6 = g.
package seg7_pkg;

   // Pattern with every segment dark
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Hex glyph table, indexed by the value each pattern represents
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

   // One captured digit slot; dot is stored active-high
   typedef struct packed {
      logic [6:0] seg;
      logic       dot;
   } digit_slot_t;

   // True when exactly one active-low strobe bit is asserted
   function automatic logic is_single_strobe(input logic [3:0] strb_n);
      logic [3:0] low;
      low = ~strb_n;
      return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
   endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational lookup of one active-low segment pattern into a hex value.
module seg7_glyph_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg,
   output logic [3:0] value,
   output logic       ok,
   output logic       blank
);

   // Match the pattern against the glyph table; unknown patterns decode to 0
   always_comb begin
      value = '0;
      ok    = 1'b0;
      blank = (seg == SEG_BLANK);
      for (int unsigned i = 0; i < 16; i++) begin
         if (seg == GLYPH_TABLE[i]) begin
            value = i[3:0];
            ok    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the four digits shown on a multiplexed seven-segment display by
// sampling its strobe/segment/dot lines, accepting each digit slot once it is
// stable, and publishing a whole frame once all four slots are captured.
module seg7_scan_decoder #(
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
   input  logic       FPGA_clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] LED_enables,
   input  logic [6:0] LED_7,
   input  logic       LED_dot,
   output logic [3:0] digit_0,
   output logic [3:0] digit_1,
   output logic [3:0] digit_2,
   output logic [3:0] digit_3,
   output logic [6:0] raw_0,
   output logic [6:0] raw_1,
   output logic [6:0] raw_2,
   output logic [6:0] raw_3,
   output logic [3:0] dots,
   output logic [3:0] glyph_ok,
   output logic [3:0] blank,
   output logic       frame_valid,
   output logic       stale
);
   import seg7_pkg::*;

   localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
   localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

   // Input synchronizers
   logic [3:0]        strb_s1, strb_s2;
   logic [6:0]        seg_s1, seg_s2;
   logic              dot_s1, dot_s2;
   logic              en_d;

   // Registered state and its next values
   logic [3:0]        prev_strb, prev_strb_n;
   logic [6:0]        prev_seg, prev_seg_n;
   logic              prev_dot, prev_dot_n;
   logic [STAB_W-1:0] stab_cnt, stab_n;
   logic [IDLE_W-1:0] idle_cnt, idle_n;
   logic [3:0]        captured_mask, mask_n;
   digit_slot_t       shadow [4];
   digit_slot_t       shadow_n [4];
   digit_slot_t       out_slot [4];
   digit_slot_t       out_n [4];
   logic              frame_valid_n, stale_n;

   // Combinational helpers
   logic              sample_valid, same_sample, accept;
   logic [1:0]        slot_idx;
   logic [3:0]        mask_work;
   logic [3:0]        digit_arr [4];

   // Classify the synchronized sample and locate its strobed slot
   always_comb begin
      sample_valid = is_single_strobe(strb_s2);
      same_sample  = (strb_s2 == prev_strb) && (seg_s2 == prev_seg) && (dot_s2 == prev_dot);
      slot_idx     = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!strb_s2[i]) slot_idx = 2'(i);
      end
   end

   // Next-state logic: stability counting, slot acceptance, frame publish, timeout
   always_comb begin
      prev_strb_n   = prev_strb;
      prev_seg_n    = prev_seg;
      prev_dot_n    = prev_dot;
      stab_n        = stab_cnt;
      idle_n        = idle_cnt;
      mask_n        = captured_mask;
      shadow_n      = shadow;
      out_n         = out_slot;
      frame_valid_n = 1'b0;
      stale_n       = stale;
      accept        = 1'b0;
      mask_work     = captured_mask;

      if (en) begin
         prev_strb_n = strb_s2;
         prev_seg_n  = seg_s2;
         prev_dot_n  = dot_s2;

         if (!en_d || !sample_valid) begin
            stab_n = '0;
         end else if (same_sample && (stab_cnt != '0)) begin
            if (stab_cnt != STAB_MAX) stab_n = stab_cnt + STAB_W'(1);
         end else begin
            stab_n = STAB_W'(1);
         end

         // A slot held past the threshold sits at STAB_MAX and is not re-accepted
         accept = en_d && sample_valid && (stab_n == STAB_MAX) &&
                  !(same_sample && (stab_cnt == STAB_MAX));

         // Publish first so a same-cycle acceptance lands in the next frame
         if (captured_mask == 4'hF) begin
            out_n         = shadow;
            frame_valid_n = 1'b1;
            stale_n       = 1'b0;
            mask_work     = '0;
         end

         if (accept) begin
            shadow_n[slot_idx]  = '{seg: seg_s2, dot: ~dot_s2};
            mask_work[slot_idx] = 1'b1;
            idle_n              = '0;
         end else if (idle_cnt != IDLE_MAX) begin
            idle_n = idle_cnt + IDLE_W'(1);
         end

         if (!accept && (idle_n == IDLE_MAX)) begin
            stale_n   = 1'b1;
            mask_work = '0;
         end

         mask_n = mask_work;
      end
   end

   // State registers, including the two-flop input synchronizers
   always_ff @(posedge FPGA_clk or negedge rst) begin
      if (!rst) begin
         strb_s1       <= 4'hF;
         strb_s2       <= 4'hF;
         seg_s1        <= SEG_BLANK;
         seg_s2        <= SEG_BLANK;
         dot_s1        <= 1'b1;
         dot_s2        <= 1'b1;
         en_d          <= 1'b0;
         prev_strb     <= 4'hF;
         prev_seg      <= SEG_BLANK;
         prev_dot      <= 1'b1;
         stab_cnt      <= '0;
         idle_cnt      <= '0;
         captured_mask <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            shadow[i]   <= '{seg: SEG_BLANK, dot: 1'b0};
            out_slot[i] <= '{seg: SEG_BLANK, dot: 1'b0};
         end
         frame_valid   <= 1'b0;
         stale         <= 1'b1;
      end else begin
         strb_s1       <= LED_enables;
         strb_s2       <= strb_s1;
         seg_s1        <= LED_7;
         seg_s2        <= seg_s1;
         dot_s1        <= LED_dot;
         dot_s2        <= dot_s1;
         en_d          <= en;
         prev_strb     <= prev_strb_n;
         prev_seg      <= prev_seg_n;
         prev_dot      <= prev_dot_n;
         stab_cnt      <= stab_n;
         idle_cnt      <= idle_n;
         captured_mask <= mask_n;
         shadow        <= shadow_n;
         out_slot      <= out_n;
         frame_valid   <= frame_valid_n;
         stale         <= stale_n;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_dec
      seg7_glyph_decode u_dec (
         .seg   (out_slot[g].seg),
         .value (digit_arr[g]),
         .ok    (glyph_ok[g]),
         .blank (blank[g])
      );
   end

   assign raw_0   = out_slot[0].seg;
   assign raw_1   = out_slot[1].seg;
   assign raw_2   = out_slot[2].seg;
   assign raw_3   = out_slot[3].seg;
   assign dots    = {out_slot[3].dot, out_slot[2].dot, out_slot[1].dot, out_slot[0].dot};
   assign digit_0 = digit_arr[0];
   assign digit_1 = digit_arr[1];
   assign digit_2 = digit_arr[2];
   assign digit_3 = digit_arr[3];

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus randomized frames,
// checked against a slot/frame level reference model.
module tb_seg7_scan_decoder;

   localparam int unsigned STABLE  = 16;
   localparam int unsigned TIMEOUT = 1000;

   logic       FPGA_clk = 1'b0;
   logic       rst, en, LED_dot;
   logic [3:0] LED_enables;
   logic [6:0] LED_7;
   logic [3:0] digit_0, digit_1, digit_2, digit_3;
   logic [6:0] raw_0, raw_1, raw_2, raw_3;
   logic [3:0] dots, glyph_ok, blank;
   logic       frame_valid, stale;

   always #5 FPGA_clk = ~FPGA_clk;

   seg7_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .FPGA_clk    (FPGA_clk),
      .rst         (rst),
      .en          (en),
      .LED_enables (LED_enables),
      .LED_7       (LED_7),
      .LED_dot     (LED_dot),
      .digit_0     (digit_0),
      .digit_1     (digit_1),
      .digit_2     (digit_2),
      .digit_3     (digit_3),
      .raw_0       (raw_0),
      .raw_1       (raw_1),
      .raw_2       (raw_2),
      .raw_3       (raw_3),
      .dots        (dots),
      .glyph_ok    (glyph_ok),
      .blank       (blank),
      .frame_valid (frame_valid),
      .stale       (stale)
   );

   logic [6:0] GT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;
   int unsigned fv_seen = 0;

   // Reference model: published digits, shadow digits, capture mask, stale flag
   logic [6:0]  m_out_seg [4];
   logic        m_out_dot [4];
   logic [6:0]  m_sh_seg [4];
   logic        m_sh_dot [4];
   logic [3:0]  m_mask;
   logic        m_stale;
   int unsigned m_frames = 0;

   // Count every cycle frame_valid is high; a one-cycle pulse adds exactly one
   always @(negedge FPGA_clk) if (frame_valid === 1'b1) fv_seen++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_decode(input logic [6:0] s, output logic [3:0] v,
                                      output logic ok, output logic bl);
      v  = 4'h0;
      ok = 1'b0;
      bl = (s == 7'h7F);
      for (int i = 0; i < 16; i++) begin
         if (GT[i] == s) begin
            v  = i[3:0];
            ok = 1'b1;
         end
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_out_seg[i] = 7'h7F; m_out_dot[i] = 1'b0;
         m_sh_seg[i]  = 7'h7F; m_sh_dot[i]  = 1'b0;
      end
      m_mask  = 4'h0;
      m_stale = 1'b1;
   endtask

   // Show one digit slot for len cycles; a long enough hold with capture enabled is accepted
   task automatic drive_slot(input int slot, input logic [6:0] seg, input logic dot, input int len);
      LED_enables = ~(4'b0001 << slot);
      LED_7       = seg;
      LED_dot     = ~dot;
      repeat (len) @(negedge FPGA_clk);
      if (en && len >= STABLE) begin
         m_sh_seg[slot] = seg;
         m_sh_dot[slot] = dot;
         m_mask[slot]   = 1'b1;
         if (m_mask == 4'hF) begin
            for (int i = 0; i < 4; i++) begin
               m_out_seg[i] = m_sh_seg[i];
               m_out_dot[i] = m_sh_dot[i];
            end
            m_mask  = 4'h0;
            m_stale = 1'b0;
            m_frames++;
         end
      end
   endtask

   task automatic drive_idle(input int len);
      LED_enables = 4'hF;
      LED_7       = 7'h7F;
      LED_dot     = 1'b1;
      repeat (len) @(negedge FPGA_clk);
   endtask

   task automatic check_outputs(input string tag);
      logic [27:0] e_raw;
      logic [15:0] e_dig;
      logic [3:0]  e_ok, e_bl, e_dot, v;
      logic        ok, bl;
      for (int i = 0; i < 4; i++) begin
         ref_decode(m_out_seg[i], v, ok, bl);
         e_raw[i*7 +: 7] = m_out_seg[i];
         e_dig[i*4 +: 4] = v;
         e_ok[i]  = ok;
         e_bl[i]  = bl;
         e_dot[i] = m_out_dot[i];
      end
      chk({tag, ".raw"},      {raw_3, raw_2, raw_1, raw_0}, e_raw);
      chk({tag, ".digits"},   {digit_3, digit_2, digit_1, digit_0}, e_dig);
      chk({tag, ".glyph_ok"}, glyph_ok, e_ok);
      chk({tag, ".blank"},    blank, e_bl);
      chk({tag, ".dots"},     dots, e_dot);
      chk({tag, ".stale"},    stale, m_stale);
      chk({tag, ".frames"},   fv_seen, m_frames);
   endtask

   function automatic logic [6:0] rand_pattern();
      int unsigned r;
      r = $urandom_range(0, 5);
      if (r == 0) return 7'h7F;
      if (r == 1) return 7'($urandom_range(0, 127));
      return GT[$urandom_range(0, 15)];
   endfunction

   // One frame of random content in random slot order, with occasional short glitches
   task automatic random_frame(input int nslots);
      int order [4] = '{0, 1, 2, 3};
      int j, t;
      logic [6:0] s;
      for (int i = 3; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int k = 0; k < nslots; k++) begin
         s = rand_pattern();
         if ($urandom_range(0, 2) == 0)
            drive_slot(order[k], s ^ 7'h01, 1'b0, $urandom_range(1, STABLE - 1));
         drive_slot(order[k], s, 1'($urandom_range(0, 1)), $urandom_range(20, 40));
      end
   endtask

   initial begin
      rst = 1'b0; en = 1'b1;
      LED_enables = 4'hF; LED_7 = 7'h7F; LED_dot = 1'b1;
      model_reset();
      repeat (3) @(negedge FPGA_clk);
      check_outputs("reset");
      chk("reset.frame_valid", frame_valid, 1'b0);
      chk("reset.blank_const", blank, 4'hF);
      rst = 1'b1;
      drive_idle(2);

      // Directed frame 3..0 with dot on digit 2
      drive_slot(3, 7'h30, 1'b0, 40);
      drive_slot(2, 7'h24, 1'b1, 40);
      drive_slot(1, 7'h79, 1'b0, 40);
      drive_slot(0, 7'h40, 1'b0, 40);
      drive_idle(5);
      check_outputs("frame3210");
      chk("frame3210.digits_const", {digit_3, digit_2, digit_1, digit_0}, 16'h3210);
      chk("frame3210.dots_const", dots, 4'b0100);

      // One slot accepted, then a 15-cycle hold that changes before acceptance
      drive_slot(0, 7'h19, 1'b0, 30);
      drive_slot(2, 7'h12, 1'b0, STABLE - 1);
      LED_7 = 7'h02;
      repeat (3) @(negedge FPGA_clk);
      drive_idle(5);
      chk("hold15.mask", dut.captured_mask, m_mask);

      // Two strobes low at once never qualifies
      LED_enables = 4'b1100; LED_7 = 7'h00; LED_dot = 1'b1;
      repeat (50) @(negedge FPGA_clk);
      chk("multi.stab_mid", dut.stab_cnt, 0);
      repeat (50) @(negedge FPGA_clk);
      chk("multi.stab_end", dut.stab_cnt, 0);
      chk("multi.mask", dut.captured_mask, m_mask);
      drive_idle(3);
      drive_slot(1, 7'h08, 1'b1, 30);
      drive_slot(2, 7'h03, 1'b0, 30);
      drive_slot(3, 7'h46, 1'b0, 30);
      drive_idle(5);
      check_outputs("after_multi");

      // Blank and unknown patterns
      drive_slot(3, 7'h46, 1'b0, 30);
      drive_slot(2, 7'h0E, 1'b0, 30);
      drive_slot(1, 7'h7F, 1'b0, 30);
      drive_slot(0, 7'h55, 1'b0, 30);
      drive_idle(5);
      check_outputs("blank_unknown");
      chk("blank_unknown.blank_const", blank, 4'b0010);
      chk("blank_unknown.ok_low", glyph_ok[1:0], 2'b00);
      chk("blank_unknown.d0", digit_0, 4'h0);

      // Randomized frames
      for (int f = 0; f < 12; f++) begin
         random_frame(4);
         drive_idle(5);
         check_outputs($sformatf("rand%0d", f));
      end

      // Capture disabled: nothing is accepted or published
      en = 1'b0;
      random_frame(4);
      drive_idle(3);
      check_outputs("en_low");
      chk("en_low.mask", dut.captured_mask, m_mask);
      en = 1'b1;
      drive_idle(3);

      // Timeout with a partial frame pending
      random_frame(2);
      chk("pre_timeout.mask", dut.captured_mask, m_mask);
      drive_idle(TIMEOUT + 20);
      m_mask  = 4'h0;
      m_stale = 1'b1;
      check_outputs("timeout");
      chk("timeout.mask", dut.captured_mask, m_mask);
      random_frame(4);
      drive_idle(5);
      check_outputs("after_timeout");

      // Reset in the middle of a frame discards the partial capture
      random_frame(2);
      rst = 1'b0;
      repeat (3) @(negedge FPGA_clk);
      model_reset();
      check_outputs("rst_mid");
      chk("rst_mid.mask", dut.captured_mask, 4'h0);
      rst = 1'b1;
      drive_idle(2);
      drive_slot(0, 7'h79, 1'b0, 30);
      drive_slot(1, 7'h24, 1'b0, 30);
      drive_idle(5);
      check_outputs("rst_two");
      drive_slot(2, 7'h30, 1'b1, 30);
      drive_slot(3, 7'h19, 1'b0, 30);
      drive_idle(5);
      check_outputs("rst_four");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
